decode_dataflow_ctrl: RTL and testbench

Sequencer for the decode dataflow chain (castIn, conv4, upsamp4, conv5, upsamp5, conv6, upsamp6, conv7, castOut). It accepts one frame request over an ap_ctrl_chain-style top handshake, launches every stage, collects their completion handshakes and reports frame done. It also runs a hardware stall watchdog that latches a sticky deadlock flag when every busy stage is FIFO-blocked for too long. It is the synthesizable, in-fabric counterpart of the simulation-only deadlock monitor.

---
 rtl/decode_dataflow_ctrl.sv | 136 +++++++++++++
 tb/tb_decode_dataflow_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dataflow_ctrl.sv
// decode_dataflow_ctrl: frame sequencer for the decode dataflow chain, with an
// in-fabric stall watchdog that latches a sticky deadlock flag.
`default_nettype none

module decode_dataflow_ctrl #(
  parameter int N_STAGES    = 9,
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W       = 32
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic                ap_done,
  input  logic                ap_continue,
  output logic                ap_idle,
  output logic [N_STAGES-1:0] stg_start,
  input  logic [N_STAGES-1:0] stg_ready,
  input  logic [N_STAGES-1:0] stg_done,
  output logic [N_STAGES-1:0] stg_continue,
  input  logic [N_STAGES-1:0] stg_idle,
  input  logic [N_STAGES-1:0] stg_block,
  output logic                deadlock,
  output logic [CNT_W-1:0]    frame_cnt
);

  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [N_STAGES-1:0] start_pend_q, start_pend_d;
  logic [N_STAGES-1:0] done_seen_q, done_seen_d;
  logic [SC_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                ap_ready_q, ap_ready_d;
  logic                ap_done_q, ap_done_d;
  logic                deadlock_q, deadlock_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

  logic [N_STAGES-1:0] accept_w, fin_w, busy_w;
  logic                stall_w;

  assign stg_continue = {N_STAGES{state_q == S_RUN}} & ~done_seen_q;
  assign ap_idle      = (state_q == S_IDLE);
  assign stg_start    = start_pend_q;
  assign ap_ready     = ap_ready_q;
  assign ap_done      = ap_done_q;
  assign deadlock     = deadlock_q;
  assign frame_cnt    = frame_cnt_q;

  assign accept_w = start_pend_q & stg_ready;
  assign fin_w    = stg_done & stg_continue;
  // A stage that already reported done no longer counts as busy.
  assign busy_w   = ~stg_idle & ~done_seen_q;
  assign stall_w  = (busy_w != '0) && ((busy_w & ~stg_block) == '0);

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    done_seen_d  = done_seen_q;
    stall_cnt_d  = '0;
    ap_ready_d   = 1'b0;
    ap_done_d    = ap_done_q;
    deadlock_d   = deadlock_q;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d      = S_RUN;
          start_pend_d = '1;
          done_seen_d  = '0;
        end
      end
      S_RUN: begin
        start_pend_d = start_pend_q & ~accept_w;
        done_seen_d  = done_seen_q | fin_w;
        ap_ready_d   = (start_pend_q != '0) && (start_pend_d == '0);
        if (stall_w && (stall_cnt_q == STALL_LAST)) begin
          state_d      = S_HALT;
          deadlock_d   = 1'b1;
          start_pend_d = '0;
          ap_ready_d   = 1'b0;
        end else begin
          if (stall_w) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
          if ((start_pend_d == '0) && (&done_seen_d)) begin
            state_d   = S_DONE;
            ap_done_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (ap_continue) begin
          state_d     = S_IDLE;
          ap_done_d   = 1'b0;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= S_IDLE;
      start_pend_q <= '0;
      done_seen_q  <= '0;
      stall_cnt_q  <= '0;
      ap_ready_q   <= 1'b0;
      ap_done_q    <= 1'b0;
      deadlock_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      done_seen_q  <= done_seen_d;
      stall_cnt_q  <= stall_cnt_d;
      ap_ready_q   <= ap_ready_d;
      ap_done_q    <= ap_done_d;
      deadlock_q   <= deadlock_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_dataflow_ctrl.sv
// tb_decode_dataflow_ctrl: randomized frames against a timeline model of each
// stage's accept/done cycle, plus reset, watchdog and counter-wrap scenarios.
`default_nettype none

module tb_decode_dataflow_ctrl;

  localparam int NS  = 9;
  localparam int LIM = 16;
  localparam int CW  = 2;

  logic          ap_clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          ap_rst, ap_start, ap_continue;
  logic          ap_ready, ap_done, ap_idle, deadlock;
  logic [NS-1:0] stg_start, stg_ready, stg_done, stg_continue, stg_idle, stg_block;
  logic [CW-1:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int frames  = 0;

  always #5 if (clk_en) ap_clk = ~ap_clk;

  decode_dataflow_ctrl #(.N_STAGES(NS), .STALL_LIMIT(LIM), .CNT_W(CW)) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .ap_idle     (ap_idle),
    .stg_start   (stg_start),
    .stg_ready   (stg_ready),
    .stg_done    (stg_done),
    .stg_continue(stg_continue),
    .stg_idle    (stg_idle),
    .stg_block   (stg_block),
    .deadlock    (deadlock),
    .frame_cnt   (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [NS-1:0] rbits();
    return NS'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] exp_cnt();
    return 32'(frames % (1 << CW));
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_idle"}, 32'(ap_idle), 32'd1);
    chk({tag, "_ready"}, 32'(ap_ready), 32'd0);
    chk({tag, "_done"}, 32'(ap_done), 32'd0);
    chk({tag, "_deadlock"}, 32'(deadlock), 32'd0);
    chk({tag, "_stg_start"}, 32'(stg_start), 32'd0);
    chk({tag, "_stg_cont"}, 32'(stg_continue), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  task automatic idle_cycle;
    chk("idle_idle", 32'(ap_idle), 32'd1);
    chk("idle_done", 32'(ap_done), 32'd0);
    chk("idle_start", 32'(stg_start), 32'd0);
    chk("idle_deadlock", 32'(deadlock), 32'd0);
    chk("idle_cnt", 32'(frame_cnt), exp_cnt());
    ap_start    = 1'b0;
    ap_continue = rbit();
    stg_ready   = rbits();
    stg_done    = rbits();
    stg_idle    = rbits();
    stg_block   = rbits();
    tick;
  endtask

  // Stage i is ready first in cycle r[i] and reports done in cycle d[i]
  // (cycles counted from the edge that samples ap_start); the top
  // acknowledges w cycles after ap_done first appears.
  task automatic run_frame(input int r[NS], input int d[NS], input int w);
    int rmax, dmax, t_done, k;
    rmax = 0; dmax = 0; k = 0;
    for (int i = 0; i < NS; i++) begin
      if (r[i] > rmax) rmax = r[i];
      if (d[i] > dmax) begin dmax = d[i]; k = i; end
    end
    t_done = ((rmax > dmax) ? rmax : dmax) + 1;
    chk("f0_idle", 32'(ap_idle), 32'd1);
    chk("f0_done", 32'(ap_done), 32'd0);
    chk("f0_cnt", 32'(frame_cnt), exp_cnt());
    ap_start = 1'b1; ap_continue = 1'b0;
    stg_ready = '0; stg_done = '0; stg_idle = rbits(); stg_block = rbits();
    tick;
    for (int n = 1; n <= t_done + w; n++) begin
      logic [NS-1:0] es, ec;
      for (int i = 0; i < NS; i++) begin
        es[i] = (n <= r[i]);
        ec[i] = (n < t_done) && (n <= d[i]);
      end
      chk("stg_start", 32'(stg_start), 32'(es));
      chk("stg_continue", 32'(stg_continue), 32'(ec));
      chk("ap_ready", 32'(ap_ready), 32'(n == rmax + 1));
      chk("ap_done", 32'(ap_done), 32'(n >= t_done));
      chk("ap_idle", 32'(ap_idle), 32'd0);
      chk("deadlock", 32'(deadlock), 32'd0);
      chk("frame_cnt", 32'(frame_cnt), exp_cnt());
      for (int i = 0; i < NS; i++) begin
        stg_ready[i] = (n == r[i]) || ((n > r[i]) && rbit());
        stg_done[i]  = (n == d[i]) || ((n > d[i]) && rbit());
      end
      // Keep the last-finishing stage busy and unblocked so no stall arises.
      stg_idle = rbits();  stg_idle[k]  = 1'b0;
      stg_block = rbits(); stg_block[k] = 1'b0;
      ap_start    = (n >= t_done) ? 1'b1 : rbit();
      ap_continue = (n < t_done) ? rbit() : 1'(n == t_done + w);
      tick;
    end
    frames++;
  endtask

  task automatic watchdog_run;
    logic [NS-1:0] es, ec;
    int run;
    bit halted, stall_n;
    run = 0; halted = 1'b0;
    ap_start = 1'b1; ap_continue = 1'b0;
    stg_ready = '0; stg_done = '0; stg_idle = '0; stg_block = '0;
    tick;
    for (int n = 1; n <= 40; n++) begin
      es = (n == 1) ? '1 : NS'(9'b000000010);
      ec = (n == 1) ? '1 : NS'(9'b000000110);
      if (halted) begin es = '0; ec = '0; end
      chk("wd_deadlock", 32'(deadlock), 32'(halted));
      chk("wd_stg_start", 32'(stg_start), 32'(es));
      chk("wd_stg_cont", 32'(stg_continue), 32'(ec));
      chk("wd_ready", 32'(ap_ready), 32'd0);
      chk("wd_done", 32'(ap_done), 32'd0);
      chk("wd_idle", 32'(ap_idle), 32'd0);
      stg_ready = (n == 1) ? ~NS'(9'b000000010) : '0;
      stg_done  = (n == 1) ? ~NS'(9'b000000110) : '0;
      stg_idle  = (n == 1) ? '0 : ~NS'(9'b000000110);
      stg_block = (n == 1) ? '0 : ((n == 11) ? NS'(9'b000000010) : NS'(9'b000000110));
      ap_start  = (n >= 30);
      stall_n   = (n >= 2) && (n != 11);
      if (!halted) begin
        run = stall_n ? run + 1 : 0;
        if (run == LIM) halted = 1'b1;
      end
      tick;
    end
    chk("wd_halted_model", 32'(halted), 32'd1);
    #2 ap_rst = 1'b1;
    #1 check_reset_vals("wd_rst");
    tick;
    ap_rst = 1'b0;
    frames = 0;
  endtask

  initial begin
    int r[NS];
    int d[NS];
    ap_rst = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    stg_ready = '0; stg_done = '0; stg_idle = '0; stg_block = '0;
    #2 ap_rst = 1'b1;
    #1 check_reset_vals("por");
    clk_en = 1'b1;
    tick; tick;
    ap_rst = 1'b0;
    idle_cycle;

    for (int i = 0; i < NS; i++) begin r[i] = 1; d[i] = 3 + i; end
    run_frame(r, d, 0);
    idle_cycle;

    for (int i = 0; i < NS; i++) begin r[i] = 1; d[i] = $urandom_range(1, 8); end
    r[3] = 5;
    run_frame(r, d, $urandom_range(0, 3));
    idle_cycle;

    for (int i = 0; i < NS; i++) begin r[i] = $urandom_range(1, 4); d[i] = $urandom_range(1, 9); end
    run_frame(r, d, 20);
    for (int i = 0; i < NS; i++) begin r[i] = $urandom_range(1, 4); d[i] = $urandom_range(1, 9); end
    run_frame(r, d, 1);
    idle_cycle;

    watchdog_run;
    idle_cycle;

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NS; i++) begin
        r[i] = $urandom_range(1, 6);
        d[i] = $urandom_range(1, 12);
      end
      run_frame(r, d, $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) idle_cycle;
    end
    idle_cycle;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
